// File: rtl/seg7_display_scan.sv
// Binary-to-BCD (double-dabble) converter feeding a multiplexed 7-segment scanner.
// Latency: start sampled at edge k -> done pulse WIDTH+1 edges later; an/seg lag the digit index by one cycle.
// Backpressure: start is accepted only while busy=0; a start seen while busy is dropped, never queued.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_display_scan #(
   parameter int WIDTH       = 11,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  bin_in,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg
);

   // Every 3 binary bits need at most one decimal digit; always keep at least one
   // nibble above the display so values past 10^DIGITS-1 remain visible.
   localparam int NIB_NEED = (WIDTH + 2) / 3;
   localparam int BCD_NIB  = (NIB_NEED > DIGITS) ? NIB_NEED : DIGITS + 1;
   localparam int BCD_W    = 4 * BCD_NIB;
   localparam int DISP_W   = 4 * DIGITS;
   localparam int CNT_W    = $clog2(WIDTH + 1);
   localparam int REF_W    = $clog2(REFRESH_DIV);
   localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DISP_W-1:0]  disp_q, disp_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DIGITS-1:0]  an_q, an_d;
   logic [6:0]         seg_q, seg_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [3:0]         cur_nib;
   logic               blank_cur;

   // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles go dark.
   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   // Double-dabble correction: add 3 to every nibble that would overflow on the next shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_NIB; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM next-state: capture, WIDTH shift steps, then latch to the display.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin_in;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Top bit of the corrected value cannot be set for in-range inputs; it is dropped by the shift.
            bcd_d = BCD_W'({bcd_adj, sh_q[WIDTH-1]});
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            disp_d  = bcd_q[DISP_W-1:0];
            ovf_d   = |bcd_q[BCD_W-1:DISP_W];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Select the nibble for the digit currently being scanned.
   always_comb begin
      cur_nib = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib = disp_q[4*i +: 4];
         end
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] lead_zero;

   // lead_zero[i]: this digit and every digit above it are zero, so digit i is a leading zero.
   always_comb begin
      lead_zero             = '0;
      lead_zero[DIGITS-1]   = (disp_q[DISP_W-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         lead_zero[i] = lead_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
      end
      blank_cur = 1'b0;
      for (int i = 1; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            blank_cur = lead_zero[i];
         end
      end
   end
`else
   // Every digit shows its value, leading zeros included.
   always_comb begin
      blank_cur = 1'b0;
   end
`endif

   // Scan timing and registered digit drive; overflow dashes win over blanking.
   always_comb begin
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
         ref_d = ref_q + 1'b1;
         idx_d = idx_q;
      end
      an_d = ~(DIGITS'(1) << idx_q);
      if (ovf_q) begin
         seg_d = 7'h3F;
      end else if (blank_cur) begin
         seg_d = 7'h7F;
      end else begin
         seg_d = seg_code(cur_nib);
      end
   end

   // State registers; reset aborts any conversion and darkens the display.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= 7'h7F;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign an       = an_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_seg7_display_scan.sv
// Directed bench for seg7_display_scan: latency, digit codes, overflow, restart rejection, reset abort, scan order.
// Expected values come from a decimal reference model and a scoreboard queue of submitted values.
// Three instances share stimulus: fast-scan 4-digit, fast-scan 3-digit, and default parameters.
module tb_seg7_display_scan;

   logic        clk;
   logic        rst;
   logic [10:0] bin_in;
   logic        start;

   logic       busy_a, done_a, ovf_a;
   logic [3:0] an_a;
   logic [6:0] seg_a;
   logic       busy_b, done_b, ovf_b;
   logic [2:0] an_b;
   logic [6:0] seg_b;
   logic       busy_d, done_d, ovf_d;
   logic [3:0] an_d;
   logic [6:0] seg_d;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   seg7_display_scan #(.WIDTH(11), .DIGITS(4), .REFRESH_DIV(4)) u_a (
      .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
      .busy(busy_a), .done(done_a), .overflow(ovf_a), .an(an_a), .seg(seg_a));

   seg7_display_scan #(.WIDTH(11), .DIGITS(3), .REFRESH_DIV(4)) u_b (
      .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
      .busy(busy_b), .done(done_b), .overflow(ovf_b), .an(an_b), .seg(seg_b));

   seg7_display_scan u_d (
      .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
      .busy(busy_d), .done(done_d), .overflow(ovf_d), .an(an_d), .seg(seg_d));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pow10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   // Reference: segment pattern for digit i of value v on a d-digit display.
   function automatic logic [6:0] exp_seg(input int v, input int i, input int d);
      int dig;
      if (v >= pow10(d)) return 7'h3F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (i > 0 && v < pow10(i)) return 7'h7F;
`endif
      dig = (v / pow10(i)) % 10;
      case (dig)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h10;
      endcase
   endfunction

   // Watch a few full scan rounds and compare every digit of both fast-scan instances.
   task automatic scan_check(input int v);
      logic [6:0] sa [4];
      logic [6:0] sb [3];
      int badpat;
      int hit;
      badpat = 0;
      for (int i = 0; i < 4; i++) sa[i] = 7'h55;
      for (int i = 0; i < 3; i++) sb[i] = 7'h55;
      step();
      for (int c = 0; c < 20; c++) begin
         step();
         hit = 0;
         for (int i = 0; i < 4; i++) begin
            if (an_a == ~(4'b0001 << i)) begin sa[i] = seg_a; hit++; end
         end
         if (hit != 1) badpat++;
         hit = 0;
         for (int i = 0; i < 3; i++) begin
            if (an_b == ~(3'b001 << i)) begin sb[i] = seg_b; hit++; end
         end
         if (hit != 1) badpat++;
      end
      chk($sformatf("an_onehot v=%0d", v), badpat, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("seg4 v=%0d dig%0d", v, i), {25'd0, sa[i]}, {25'd0, exp_seg(v, i, 4)});
      for (int i = 0; i < 3; i++) chk($sformatf("seg3 v=%0d dig%0d", v, i), {25'd0, sb[i]}, {25'd0, exp_seg(v, i, 3)});
   endtask

   // One conversion; optionally re-assert start (with another value) restart_at edges after the first.
   task automatic convert(input int v, input int restart_at, input int restart_val);
      int n, busy_n, extra, ev;
      exp_q.push_back(v);
      bin_in = 11'(v);
      start  = 1'b1;
      step();
      start  = 1'b0;
      busy_n = busy_a ? 1 : 0;
      n = 0;
      while (!done_a && n < 40) begin
         if (n == restart_at - 1) begin
            bin_in = 11'(restart_val);
            start  = 1'b1;
         end
         step();
         start = 1'b0;
         n++;
         if (busy_a) busy_n++;
      end
      chk($sformatf("latency v=%0d", v), n, 12);
      chk($sformatf("busy_cycles v=%0d", v), busy_n, 12);
      chk($sformatf("done_default v=%0d", v), {31'd0, done_d}, 1);
      ev = exp_q.pop_front();
      chk($sformatf("ovf4 v=%0d", ev), {31'd0, ovf_a}, (ev > 9999) ? 1 : 0);
      chk($sformatf("ovf3 v=%0d", ev), {31'd0, ovf_b}, (ev > 999) ? 1 : 0);
      extra = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (done_a) extra++;
      end
      chk($sformatf("single_done v=%0d", ev), extra, 0);
      scan_check(ev);
   endtask

   initial begin
      int extra;
      rst    = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      step();
      step();
      chk("rst busy", {29'd0, busy_a, busy_b, busy_d}, 0);
      chk("rst done", {29'd0, done_a, done_b, done_d}, 0);
      chk("rst ovf", {29'd0, ovf_a, ovf_b, ovf_d}, 0);
      chk("rst an_a", {28'd0, an_a}, 32'hF);
      chk("rst an_b", {29'd0, an_b}, 32'h7);
      chk("rst an_d", {28'd0, an_d}, 32'hF);
      chk("rst seg", {11'd0, seg_a, seg_b, seg_d}, {11'd0, 7'h7F, 7'h7F, 7'h7F});

      // Scan order: each one-hot pattern held four cycles, starting one cycle after reset release.
      rst = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         step();
         chk($sformatf("an_seq c%0d", j), {28'd0, an_a}, {28'd0, ~(4'b0001 << (((j - 1) / 4) % 4))});
      end

      convert(147, 0, 0);
      convert(2046, 0, 0);
      convert(0, 0, 0);
      convert(1000, 0, 0);
      convert(999, 0, 0);
      convert(321, 3, 555);

      // Reset five cycles into a conversion: aborted, no done, display back to zero.
      bin_in = 11'd500;
      start  = 1'b1;
      step();
      start  = 1'b0;
      repeat (5) step();
      rst = 1'b1;
      step();
      chk("abort an", {28'd0, an_a}, 32'hF);
      chk("abort seg", {25'd0, seg_a}, 32'h7F);
      chk("abort busy", {31'd0, busy_a}, 0);
      rst = 1'b0;
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (done_a || done_b || done_d) extra++;
      end
      chk("abort no_done", extra, 0);
      chk("abort ovf", {31'd0, ovf_a}, 0);
      scan_check(0);

      convert(58, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_display_scan.md
SEG7_DISPLAY_SCAN -- requirements
Module: seg7_display_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, giving the binary input width (the N+1-bit sum of a 10-bit adder).
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of display digits.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 50000, giving clock cycles per digit slot (minimum 2).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 bin_in  input  WIDTH  unsigned binary value to display.
REQ-007 start  input  1  capture bin_in and begin conversion; honoured only when busy=0.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when new digits are latched to the display.
REQ-010 overflow  output  1  high while the displayed value exceeds 10^DIGITS-1.
REQ-011 an  output  DIGITS  digit enables, active-low, one-hot; bit 0 is the least significant digit.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and LATCH.
REQ-014 In IDLE with start=1, the block SHALL capture bin_in, clear the BCD scratch register and the shift counter, and enter SHIFT.
REQ-015 SHIFT SHALL perform one double-dabble step per cycle (+3 on each BCD nibble >=5, then shift left one bit from the captured value) for exactly WIDTH cycles, then enter LATCH.
REQ-016 The BCD scratch register SHALL be wide enough that any bits beyond DIGITS nibbles are retained for overflow detection.
REQ-017 LATCH SHALL copy the low DIGITS nibbles to the display register, set overflow when any higher BCD bit is nonzero, assert done for that cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed: start sampled at edge k gives done=1 during cycle k+WIDTH+1.
REQ-019 busy SHALL be 1 in SHIFT and LATCH and 0 in IDLE; start while busy=1 SHALL be ignored without being queued.
REQ-020 The display register SHALL hold its value between conversions; scanning SHALL continue uninterrupted during conversion.
REQ-021 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-022 an and seg SHALL be registered, so they reflect the digit index one cycle after it changes.
REQ-023 Digit codes (seg hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank=7F; dash=3F.
REQ-024 While overflow=1, every digit SHALL show dash.

Reset
REQ-025 On rst=1 at a clock edge: FSM to IDLE, busy=0, done=0, overflow=0, display register=0, refresh counter=0, digit index=0, an=all ones, seg=7F.
REQ-026 rst during SHIFT or LATCH SHALL abort the conversion with no done pulse; rst SHALL have priority over start.

Configuration
REQ-027 With macro SEG7_LEADING_ZERO_BLANK_EN defined, leading zero digits SHALL show blank (7F); digit 0 SHALL always show its value, so a value of 0 shows a single "0".
REQ-028 Without SEG7_LEADING_ZERO_BLANK_EN, all digits SHALL show their decimal value, including leading zeros.
REQ-029 The overflow dash display SHALL take precedence over blanking in both builds.

Verification
REQ-030 Default params, bin_in=147, start pulse -> busy for 12 cycles, done exactly 12 cycles after start; digits 0,1,4,7 (digit 0 seg=78); with blanking, digit 3 seg=7F.
REQ-031 bin_in=2046 then bin_in=0 -> digits 2,0,4,6, then all 0 without blanking, or only digit 0 = 40 with blanking; overflow=0 throughout.
REQ-032 DIGITS=3, bin_in=1000 -> overflow=1 after done, all three digits seg=3F; then bin_in=999 -> overflow=0, digits 9,9,9 (seg=10).
REQ-033 start asserted again 3 cycles after the first start -> ignored, single done pulse, first value displayed.
REQ-034 rst asserted 5 cycles into a conversion -> no done pulse, an=all ones and seg=7F on the next cycle, display register=0; a subsequent start converts normally.
REQ-035 REFRESH_DIV=4, DIGITS=4 -> an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles, only one bit low at any time.
